// File: rtl/cipher_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cipher_frame_ctrl
// Description : Framed XOR stream cipher. A 4-bit LFSR produces the key
//               nibble. Each accepted byte is XORed with {key,key} and
//               presented through a single-entry output register with a
//               valid/ready handshake. An optional warm-up discards
//               keystream steps before the first byte. The frame length
//               is counted, and done pulses once the last byte has left.
//               Optional feature macro: CIPHER_KEY_OUT_EN adds key_out[3:0],
//               which holds the key used for the current out_data.
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_frame_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] seed,
  input  logic [3:0] warmup,
  input  logic [7:0] frame_len,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
`ifdef CIPHER_KEY_OUT_EN
  ,
  output logic [3:0] key_out
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WARM  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [3:0] C_LFSR_RESET = 4'b0001;

  state_e      state_q;
  logic [3:0]  lfsr_q;
  logic [3:0]  lfsr_d;
  logic [3:0]  warm_cnt_q;
  logic [8:0]  bytes_left_q;
  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        done_q;

  logic        in_hs;
  logic        out_hs;
  logic [3:0]  seed_eff;
  logic [8:0]  frame_len_eff;

  // Next keystream state: shift left, feed back bit0 ^ bit3.
  always_comb begin
    lfsr_d = {lfsr_q[2:0], lfsr_q[0] ^ lfsr_q[3]};
  end

  // The all-zero state would lock the LFSR, so a zero seed becomes 0001.
  assign seed_eff      = (seed == 4'd0) ? C_LFSR_RESET : seed;
  // A zero frame length encodes the maximum frame of 256 bytes.
  assign frame_len_eff = (frame_len == 8'd0) ? 9'd256 : {1'b0, frame_len};

  // Input is accepted only in RUN when the output slot is free or draining now.
  assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  // Frame FSM together with the keystream, counters and output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      lfsr_q       <= C_LFSR_RESET;
      warm_cnt_q   <= 4'd0;
      bytes_left_q <= 9'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'd0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Output slot: a new byte wins over a drain, so a simultaneous
      // input and output handshake keeps out_valid high with no bubble.
      if (in_hs) begin
        out_data_q  <= in_data ^ {lfsr_q, lfsr_q};
        out_valid_q <= 1'b1;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            lfsr_q       <= seed_eff;
            warm_cnt_q   <= warmup;
            bytes_left_q <= frame_len_eff;
            state_q      <= (warmup == 4'd0) ? S_RUN : S_WARM;
          end
        end
        S_WARM: begin
          lfsr_q     <= lfsr_d;
          warm_cnt_q <= warm_cnt_q - 4'd1;
          if (warm_cnt_q == 4'd1) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // The key only moves with a consumed byte.
          if (in_hs) begin
            lfsr_q       <= lfsr_d;
            bytes_left_q <= bytes_left_q - 9'd1;
            if (bytes_left_q == 9'd1) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!out_valid_q || out_hs) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CIPHER_KEY_OUT_EN
  logic [3:0] key_q;

  // Capture the key alongside out_data so it describes the byte on display.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q <= 4'd0;
    end else if (in_hs) begin
      key_q <= lfsr_q;
    end
  end

  assign key_out = key_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cipher_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cipher_frame_ctrl
// Description : Self-checking bench for cipher_frame_ctrl. A table of frame
//               records is replayed with randomised valid/ready; expected
//               bytes are queued on each input handshake and compared on
//               each output handshake. Hand-written sequences cover output
//               back-pressure and reset in mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cipher_frame_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [3:0] seed;
  logic [3:0] warmup;
  logic [7:0] frame_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       done;
`ifdef CIPHER_KEY_OUT_EN
  logic [3:0] key_out;
`endif

  cipher_frame_ctrl u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .seed      (seed),
    .warmup    (warmup),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef CIPHER_KEY_OUT_EN
    ,
    .key_out   (key_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] seed;
    logic [3:0] warmup;
    logic [7:0] len;
    logic [7:0] data0;
    logic [7:0] step;
    int         valid_pct;
    int         ready_pct;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } frame_vec_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] key;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  function automatic logic [3:0] step4(input logic [3:0] s);
    return {s[2:0], s[0] ^ s[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int idx, input frame_vec_t v);
    logic [3:0] key;
    logic [7:0] d;
    logic [7:0] got[$];
    exp_t       e;
    int         total, sent, recv, cyc, first_hs;
    bit         last_hs_prev, done_seen, finished;

    sb.delete();
    key = (v.seed == 4'd0) ? 4'd1 : v.seed;
    repeat (int'(v.warmup)) key = step4(key);
    total = (v.len == 8'd0) ? 256 : int'(v.len);

    check($sformatf("v%0d_idle_before_start", idx), busy, 0);
    seed = v.seed; warmup = v.warmup; frame_len = v.len;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;

    sent = 0; recv = 0; cyc = 0; first_hs = -1;
    last_hs_prev = 1'b0; done_seen = 1'b0; finished = 1'b0;
    while (!finished && cyc < 4000) begin
      d = v.data0 + v.step * 8'(sent);
      in_valid  = (sent < total) && ($urandom_range(99) < v.valid_pct);
      in_data   = d;
      out_ready = ($urandom_range(99) < v.ready_pct);
      #1;
      if (done_seen) begin
        check($sformatf("v%0d_done_one_cycle", idx), done, 0);
        check($sformatf("v%0d_idle_after_done", idx), busy, 0);
        finished = 1'b1;
      end else begin
        if (done) begin
          done_seen = 1'b1;
          check($sformatf("v%0d_done_after_last_out", idx), last_hs_prev, 1);
          check($sformatf("v%0d_outputs_before_done", idx), recv, total);
        end
        last_hs_prev = 1'b0;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL v%0d_unexpected_output: got %02h with nothing expected", idx, out_data);
          end else begin
            e = sb.pop_front();
            check($sformatf("v%0d_out_data[%0d]", idx, recv), out_data, e.data);
`ifdef CIPHER_KEY_OUT_EN
            check($sformatf("v%0d_key_out[%0d]", idx, recv), key_out, e.key);
`endif
          end
          got.push_back(out_data);
          recv++;
          last_hs_prev = (recv == total);
        end
        if (in_valid && in_ready) begin
          if (first_hs < 0) first_hs = cyc;
          e.data = d ^ {key, key};
          e.key  = key;
          sb.push_back(e);
          key = step4(key);
          sent++;
        end
      end
      cyc++;
      @(negedge clk);
    end

    if (!finished) begin
      n_vec++; n_err++;
      $display("FAIL v%0d_timeout: got %0d outputs, done=%0d, required %0d outputs and done", idx, recv, done_seen, total);
    end
    check($sformatf("v%0d_byte_count", idx), recv, total);
    if (got.size() > 0) begin
      check($sformatf("v%0d_first_out", idx), got[0], v.exp_first);
      check($sformatf("v%0d_last_out", idx), got[got.size()-1], v.exp_last);
    end
    if (total == 256 && got.size() > 15) begin
      check($sformatf("v%0d_period15", idx), got[15], 8'h11);
    end
    if (v.valid_pct == 100 && v.ready_pct == 100) begin
      check($sformatf("v%0d_warm_cycles", idx), first_hs, int'(v.warmup));
    end
  endtask

  frame_vec_t vecs[6];

  initial begin
    //          seed   warm   len    data0  step   v%   r%   first  last
    vecs[0] = '{4'h1, 4'd0,  8'd3,  8'h00, 8'h00, 100, 100, 8'h11, 8'h77};
    vecs[1] = '{4'h1, 4'd2,  8'd1,  8'hA5, 8'h00, 100, 100, 8'hD2, 8'hD2};
    vecs[2] = '{4'h0, 4'd0,  8'd1,  8'h00, 8'h00, 100, 100, 8'h11, 8'h11};
    vecs[3] = '{4'h5, 4'd3,  8'd20, 8'h3C, 8'h07, 80,  50,  8'hF0, 8'h49};
    vecs[4] = '{4'h1, 4'd0,  8'd0,  8'h00, 8'h00, 100, 100, 8'h11, 8'h11};
    vecs[5] = '{4'hF, 4'd15, 8'd4,  8'hFF, 8'h01, 70,  60,  8'h00, 8'hA8};

    reset_n = 1'b0; start = 1'b0; seed = 4'd0; warmup = 4'd0; frame_len = 8'd0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
`ifdef CIPHER_KEY_OUT_EN
    check("reset_key_out", key_out, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_frame(i, vecs[i]);
    end

    // Back-pressure: first byte must hold while the sink stalls, start is ignored.
    @(negedge clk);
    seed = 4'h1; warmup = 4'd0; frame_len = 8'd2; start = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h00;
    #1 check("stall_in_ready_run", in_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; seed = 4'h9; frame_len = 8'd7; out_ready = 1'b0;
      #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data", out_data, 8'h11);
      check("stall_in_ready", in_ready, 0);
      check("stall_busy", busy, 1);
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b1;
    #1;
    check("stall_release_in_ready", in_ready, 1);
    check("stall_release_data", out_data, 8'h11);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("stall_second_valid", out_valid, 1);
    check("stall_second_data", out_data, 8'h33);
    check("stall_no_early_done", done, 0);
    @(negedge clk);
    #1;
    check("stall_done", done, 1);
    check("stall_idle", busy, 0);
    check("stall_drained", out_valid, 0);
    @(negedge clk);
    #1 check("stall_done_pulse", done, 0);

    // Reset in mid-frame: abandon without done, restart from a fresh seed.
    @(negedge clk);
    seed = 4'h1; warmup = 4'd0; frame_len = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 check("abort_no_done", done, 0);
    end
    @(negedge clk);
    reset_n = 1'b1; seed = 4'h1; warmup = 4'd0; frame_len = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
    #1;
    check("restart_busy", busy, 1);
    check("restart_in_ready", in_ready, 1);
    check("restart_no_done", done, 0);
    @(negedge clk);
    #1;
    check("restart_first_valid", out_valid, 1);
    check("restart_first_data", out_data, 8'h11);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("restart_second_data", out_data, 8'h33);
    @(negedge clk);
    #1 check("restart_done", done, 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
